mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 25 ++
 rtl/sp_ram.sv | 53 +++++
 rtl/mem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the mem_responder memory
//                target. It holds the responder state encoding, the word and
//                byte-enable widths, and the read data returned on errors and
//                writes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // Read data driven on writes, errors and whenever no read result is pending.
  localparam logic [WORD_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram
//  Description : Single-port synchronous RAM, DEPTH x 32, with per-byte write
//                enables and a registered read port. The array has no reset
//                and its contents start uninitialised.
//  Ports       : clk   - clock, rising edge
//                en    - access strobe; nothing happens when low
//                we    - 1 = write the enabled bytes, 0 = read into rdata
//                be    - byte enables, bit i covers wdata[8i+7:8i]
//                addr  - word address
//                wdata - write data
//                rdata - registered read data; holds until the next read
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram
  import mem_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Single process so every byte lane is written from one place.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule : sp_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-addressed memory target for CPU fetch and load/store
//                traffic. It accepts one request at a time over a valid/ready
//                request channel, inserts WAIT_STATES wait cycles, performs the
//                RAM access once on entry to the response state and holds the
//                response on a valid/ready response channel. Addresses at or
//                beyond DEPTH get an error response and never touch the array.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous, active-high reset
//                req_valid - request present
//                req_ready - request can be accepted (IDLE only)
//                req_write - 1 = write, 0 = read
//                req_addr  - word address
//                req_wdata - write data
//                req_be    - byte enables
//                rsp_valid - response present
//                rsp_ready - initiator takes the response
//                rsp_rdata - read data, zero for writes and errors
//                rsp_err   - address out of range
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_W      = 18,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_responder: WAIT_STATES must be within 0..15");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
    $error("mem_responder: DEPTH must be within 1..2**ADDR_W");
  end

  // ---------------------------------------------------------------------------
  // State and request latch
  // ---------------------------------------------------------------------------
  state_e              state_q,   state_d;
  logic [3:0]          cnt_q,     cnt_d;
  logic                write_q,   write_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [WORD_W-1:0]   wdata_q,   wdata_d;
  logic [BE_W-1:0]     be_q,      be_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rd_ok_q,   rd_ok_d;   // response carries RAM read data

  // Access fields: when responding straight out of IDLE the latch is not yet
  // loaded, so the live request fields are used instead.
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [WORD_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic                in_range;
  logic                enter_resp;
  logic                ram_en;
  logic [WORD_W-1:0]   ram_rdata;

  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH_EXT);

  // The one edge on which the array is touched for a transaction.
  assign enter_resp = ((state_q == IDLE) && req_valid && NO_WAIT) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  // Gated by reset so a pending write is dropped if reset arrives first.
  assign ram_en = enter_resp && in_range && !reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rsp_err_d = rsp_err_q;
    rd_ok_d   = rd_ok_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (NO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
          rd_ok_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_resp) begin
      rsp_err_d = !in_range;
      rd_ok_d   = in_range && !acc_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rsp_err_q <= rsp_err_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  sp_ram #(
    .DEPTH     (DEPTH),
    .AW        (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_write),
    .be    (acc_be),
    .addr  (acc_addr[RAM_AW-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  // The RAM read register is not reset, so it is masked unless a read result
  // is being presented.
  assign rsp_rdata = rd_ok_q ? ram_rdata : ERR_RDATA;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Three instances with
//                WAIT_STATES of 0, 1 and 3 share one clock and reset; each is
//                checked against a word-array model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 4096;
  localparam int AW    = 18;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_write;
  logic [N-1:0]         rsp_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0][3:0]    req_be;
  wire  [N-1:0]         req_ready;
  wire  [N-1:0]         rsp_valid;
  wire  [N-1:0]         rsp_err;
  wire  [N-1:0][31:0]   rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [N][DEPTH];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .ADDR_W      (AW),
      .DEPTH       (DEPTH),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .INIT_FILE   ("")
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, starting just after a clock edge.
  // delay = number of extra cycles rsp_ready is held low once rsp_valid is up.
  task automatic txn(int d, bit wr, logic [AW-1:0] addr, logic [31:0] wdata,
                     logic [3:0] be, int delay);
    bit          inr;
    logic [31:0] exp_rd;
    logic [31:0] exp_err;
    int          cyc;
    string       p;
    p       = $sformatf("d%0d %s@%0d", d, wr ? "wr" : "rd", addr);
    inr     = (addr < DEPTH);
    exp_err = inr ? 32'd0 : 32'd1;
    exp_rd  = (inr && !wr) ? mdl[d][addr[11:0]] : 32'd0;
    if (inr && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mdl[d][addr[11:0]][8*i +: 8] = wdata[8*i +: 8];
      end
    end

    check({p, " ready_idle"}, {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    rsp_ready[d] = (delay == 0);
    @(posedge clk); #1;
    // Keep a different request on the bus: it must be ignored.
    req_write[d] = ~wr;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wdata;
    req_be[d]    = ~be;
    cyc = 1;
    while (!rsp_valid[d] && cyc <= 40) begin
      check({p, " ready_busy"}, {31'd0, req_ready[d]}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    req_valid[d] = 1'b0;
    check({p, " latency"}, cyc, ws_of(d) + 1);
    check({p, " valid"}, {31'd0, rsp_valid[d]}, 32'd1);
    check({p, " ready_resp"}, {31'd0, req_ready[d]}, 32'd0);
    check({p, " rdata"}, rsp_rdata[d], exp_rd);
    check({p, " err"}, {31'd0, rsp_err[d]}, exp_err);
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      check({p, " hold_valid"}, {31'd0, rsp_valid[d]}, 32'd1);
      check({p, " hold_rdata"}, rsp_rdata[d], exp_rd);
      check({p, " hold_err"}, {31'd0, rsp_err[d]}, exp_err);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    check({p, " done_valid"}, {31'd0, rsp_valid[d]}, 32'd0);
    check({p, " done_ready"}, {31'd0, req_ready[d]}, 32'd1);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int d = 0; d < N; d++)
      for (int a = 0; a < DEPTH; a++) mdl[d][a] = 32'd0;

    // Reset state
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d rst req_ready", d), {31'd0, req_ready[d]}, 32'd1);
      check($sformatf("d%0d rst rsp_valid", d), {31'd0, rsp_valid[d]}, 32'd0);
      check($sformatf("d%0d rst rsp_rdata", d), rsp_rdata[d], 32'd0);
      check($sformatf("d%0d rst rsp_err", d),   {31'd0, rsp_err[d]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Word 3 holds the instruction, then read it back with rsp_ready high.
    txn(1, 1'b1, 18'd3, 32'hE3A01005, 4'hF, 0);
    txn(1, 1'b0, 18'd3, 32'h0, 4'h0, 0);

    // Byte-enabled merge.
    txn(1, 1'b1, 18'd10, 32'hAABBCCDD, 4'b1111, 1);
    txn(1, 1'b1, 18'd10, 32'h11223344, 4'b0011, 0);
    txn(1, 1'b0, 18'd10, 32'h0, 4'h0, 0);
    check("d1 merge model", mdl[1][10], 32'hAABB3344);

    // Three wait states, then a backpressured read.
    txn(2, 1'b1, 18'd0, 32'h0BADF00D, 4'hF, 0);
    txn(2, 1'b0, 18'd0, 32'h0, 4'h0, 0);
    txn(2, 1'b0, 18'd0, 32'h0, 4'h0, 5);

    // Out of range, and no aliasing onto addr mod DEPTH.
    txn(2, 1'b0, 18'd4096, 32'h0, 4'h0, 0);
    txn(2, 1'b1, 18'd904, 32'hCAFEF00D, 4'hF, 0);
    txn(2, 1'b1, 18'd5000, 32'hDEADBEEF, 4'hF, 2);
    txn(2, 1'b0, 18'd904, 32'h0, 4'h0, 0);
    txn(2, 1'b0, 18'h3FFFF, 32'h0, 4'h0, 1);

    // Zero-wait instance and a write with no byte enables.
    txn(0, 1'b1, 18'd7, 32'h5A5A5A5A, 4'hF, 0);
    txn(0, 1'b1, 18'd7, 32'hFFFFFFFF, 4'h0, 0);
    txn(0, 1'b0, 18'd7, 32'h0, 4'h0, 3);
    txn(0, 1'b0, 18'd4095, 32'h0, 4'h0, 0);

    // Reset during WAIT drops a pending write.
    txn(2, 1'b1, 18'd20, 32'h12345678, 4'hF, 0);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 18'd20;
    req_wdata[2] = 32'hFFFFFFFF;
    req_be[2]    = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("d2 pre-reset valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("d2 pre-reset ready", {31'd0, req_ready[2]}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("d2 mid-reset valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("d2 mid-reset ready", {31'd0, req_ready[2]}, 32'd1);
    check("d2 mid-reset err",   {31'd0, rsp_err[2]}, 32'd0);
    check("d2 mid-reset rdata", rsp_rdata[2], 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    txn(2, 1'b0, 18'd20, 32'h0, 4'h0, 0);

    // Randomized traffic on every instance against the model.
    for (int d = 0; d < N; d++) begin
      for (int a = 0; a < 16; a++)
        txn(d, 1'b1, AW'(a), $urandom, 4'hF, 0);
      for (int t = 0; t < 30; t++) begin
        logic [AW-1:0] ra;
        if ($urandom_range(0, 5) == 0)
          ra = AW'($urandom_range(DEPTH, (1 << AW) - 1));
        else
          ra = AW'($urandom_range(0, 15));
        txn(d, 1'($urandom_range(0, 1)), ra, $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_responder
`default_nettype wire
